// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo
// -----------------------------------------------------------------------------
// AXI4-Stream FIFO for the SoC streaming path. It carries tlast end to end and
// uses wrap-bit pointers, so an empty FIFO and a full FIFO are always told
// apart. It reports occupancy and packet count, and raises threshold flags.
// It has a synchronous flush. It can also run in store-and-forward packet mode.
// All storage is one memory array. The array is read combinationally at the
// read pointer, so there is no bypass path and no write-to-read forwarding.
//
// Ports
//   clk_i             : single clock; all logic on the rising edge
//   reset_i           : synchronous active-high reset
//   flush_i           : synchronous clear; same effect as reset on all state
//   s_axis_*          : input stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*          : output stream (tdata/tvalid/tlast out, tready in)
//   level_o           : entries stored (0..DEPTH)
//   almost_full_o     : level_o >= AF_THRESH
//   almost_empty_o    : level_o <= AE_THRESH
//   pkt_count_o       : stored beats that carry tlast
//   oversize_o        : sticky; a packet outgrew the FIFO in packet mode
// -----------------------------------------------------------------------------
module axis_packet_fifo #(
  parameter int DEPTH       = 8,        // power of two, >= 2
  parameter int DATA_W      = 8,
  parameter int PACKET_MODE = 0,        // 0 = cut-through, 1 = store-and-forward
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          s_axis_tdata_i,
  input  logic                       s_axis_tvalid_i,
  input  logic                       s_axis_tlast_i,
  output logic                       s_axis_tready_o,
  output logic [DATA_W-1:0]          m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  output logic                       m_axis_tlast_o,
  input  logic                       m_axis_tready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     pkt_count_o,
  output logic                       oversize_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  typedef enum logic {S_IDLE = 1'b0, S_RELEASE = 1'b1} state_e;

  logic [DATA_W:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            oversize_q, oversize_d;
  state_e          state_q, state_d;

  logic clear, empty, full, wr_en, rd_en;
  logic release_active, enter_release;

  assign clear = reset_i | flush_i;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // tready stays low while full, even when a read happens in the same cycle.
  assign s_axis_tready_o = !full && !clear;
  assign wr_en           = s_axis_tvalid_i && s_axis_tready_o;
  // A clear beats any handshake in the same cycle, so the beat is not consumed.
  assign rd_en           = m_axis_tvalid_o && m_axis_tready_i && !clear;

  // Storage is never cleared. Only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast_i, s_axis_tdata_i};
    end
  end

  assign {m_axis_tlast_o, m_axis_tdata_o} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + ONE;
    unique case ({wr_en && s_axis_tlast_i, rd_en && m_axis_tlast_o})
      2'b10:   pkt_count_d = pkt_count_q + ONE;
      2'b01:   pkt_count_d = pkt_count_q - ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      oversize_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      oversize_q  <= oversize_d;
    end
  end

  // Release FSM, state register.
  always_ff @(posedge clk_i) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Release FSM, next state. A FIFO that is full with no complete packet would
  // never drain in packet mode. RELEASE lets that partial packet out
  // cut-through until its tlast beat is read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enter_release)           state_d = S_RELEASE;
      S_RELEASE: if (rd_en && m_axis_tlast_o) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Release FSM, outputs.
  always_comb begin
    release_active = (state_q == S_RELEASE);
    enter_release  = (PACKET_MODE != 0) && (state_q == S_IDLE) &&
                     full && (pkt_count_q == '0);
    oversize_d     = oversize_q | enter_release;
  end

  // pkt_count and release fall only on a read. A raised tvalid therefore
  // stays up until the beat is taken.
  generate
    if (PACKET_MODE != 0) begin : g_pkt
      assign m_axis_tvalid_o = !empty && ((pkt_count_q != '0) || release_active);
    end else begin : g_cut
      assign m_axis_tvalid_o = !empty;
    end
  endgenerate

  assign level_o        = wr_ptr_q - rd_ptr_q;
  assign almost_full_o  = (level_o >= AF_T);
  assign almost_empty_o = (level_o <= AE_T);
  assign pkt_count_o    = pkt_count_q;
  assign oversize_o     = oversize_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo. It uses two DEPTH=8 instances:
// cut-through (c_*) and packet mode (p_*).
module tb_axis_packet_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // cut-through instance
  logic       c_rst, c_flush, c_tv, c_tl, c_rdy;
  logic [7:0] c_td, c_md;
  logic       c_trdy, c_mv, c_ml, c_af, c_ae, c_ov;
  logic [3:0] c_lvl, c_pc;
  // packet-mode instance
  logic       p_rst, p_flush, p_tv, p_tl, p_rdy;
  logic [7:0] p_td, p_md;
  logic       p_trdy, p_mv, p_ml, p_af, p_ae, p_ov;
  logic [3:0] p_lvl, p_pc;

  axis_packet_fifo #(.DEPTH(8), .DATA_W(8), .PACKET_MODE(0)) dut_ct (
    .clk_i(clk), .reset_i(c_rst), .flush_i(c_flush),
    .s_axis_tdata_i(c_td), .s_axis_tvalid_i(c_tv), .s_axis_tlast_i(c_tl),
    .s_axis_tready_o(c_trdy),
    .m_axis_tdata_o(c_md), .m_axis_tvalid_o(c_mv), .m_axis_tlast_o(c_ml),
    .m_axis_tready_i(c_rdy),
    .level_o(c_lvl), .almost_full_o(c_af), .almost_empty_o(c_ae),
    .pkt_count_o(c_pc), .oversize_o(c_ov));

  axis_packet_fifo #(.DEPTH(8), .DATA_W(8), .PACKET_MODE(1)) dut_pk (
    .clk_i(clk), .reset_i(p_rst), .flush_i(p_flush),
    .s_axis_tdata_i(p_td), .s_axis_tvalid_i(p_tv), .s_axis_tlast_i(p_tl),
    .s_axis_tready_o(p_trdy),
    .m_axis_tdata_o(p_md), .m_axis_tvalid_o(p_mv), .m_axis_tlast_o(p_ml),
    .m_axis_tready_i(p_rdy),
    .level_o(p_lvl), .almost_full_o(p_af), .almost_empty_o(p_ae),
    .pkt_count_o(p_pc), .oversize_o(p_ov));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] sb[$];
    logic [8:0] exp_beat;
    int sent, rcvd, cyc;

    c_rst = 1; c_flush = 0; c_tv = 0; c_tl = 0; c_td = 0; c_rdy = 0;
    p_rst = 1; p_flush = 0; p_tv = 0; p_tl = 0; p_td = 0; p_rdy = 0;
    tick(); tick();

    // ---------------- reset values ----------------
    check("rst_tready_during", c_trdy, 0);
    check("rst_level",         c_lvl,  0);
    c_rst = 0; p_rst = 0;
    #1;
    check("rst_tready_after",  c_trdy, 1);
    check("rst_tvalid",        c_mv,   0);
    check("rst_ae",            c_ae,   1);
    check("rst_af",            c_af,   0);
    check("rst_pkt",           c_pc,   0);
    check("rst_ovs",           c_ov,   0);
    check("rst_pk_tvalid",     p_mv,   0);
    check("rst_pk_ovs",        p_ov,   0);

    // ---------------- fill / drain (cut-through) ----------------
    $display("fill/drain");
    for (int i = 1; i <= 8; i++) begin
      c_tv = 1; c_td = 8'(i); c_tl = (i == 4 || i == 8);
      tick();
      $display("  wr 0x%02h", 8'(i));
      check("fill_level", c_lvl, i);
      check("fill_af",    c_af,  (i >= 6));
      check("fill_ae",    c_ae,  (i <= 1));
      if (i == 1) begin
        check("lat_tvalid", c_mv, 1);
        check("lat_tdata",  c_md, 8'h01);
      end
    end
    c_tv = 0; c_tl = 0;
    check("full_tready", c_trdy, 0);
    check("full_pkt",    c_pc,   2);
    c_rdy = 1;
    #1;
    check("full_tready_rd_pending", c_trdy, 0);
    for (int i = 1; i <= 8; i++) begin
      check("drain_beat", {c_ml, c_md}, {(i == 4 || i == 8), 8'(i)});
      tick();
      $display("  rd 0x%02h", 8'(i));
      if (i == 1) check("drain_tready_back", c_trdy, 1);
    end
    c_rdy = 0;
    check("drain_tvalid", c_mv,  0);
    check("drain_level",  c_lvl, 0);
    check("drain_pkt",    c_pc,  0);
    check("drain_ae",     c_ae,  1);

    // ---------------- wrap and concurrency ----------------
    $display("stream 100 beats");
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 100 || rcvd < 100) && cyc < 3000) begin
      c_tv  = (sent < 100) && ($urandom_range(0, 3) != 0);
      c_td  = 8'(sent);
      c_tl  = ((sent % 5) == 4);
      c_rdy = ($urandom_range(0, 2) != 0);
      #2;
      check("strm_level", c_lvl, sb.size());
      if (c_mv && c_rdy) begin
        if (sb.size() == 0) begin
          check("strm_spurious", 1, 0);
        end else begin
          exp_beat = sb.pop_front();
          check("strm_beat", {c_ml, c_md}, exp_beat);
          $display("  beat %0d data=0x%02h last=%0b", rcvd, c_md, c_ml);
          rcvd++;
        end
      end
      if (c_tv && c_trdy) begin
        sb.push_back({c_tl, c_td});
        sent++;
      end
      tick();
      cyc++;
    end
    c_tv = 0; c_rdy = 0; c_tl = 0;
    check("strm_received", rcvd, 100);
    check("strm_end_level", c_lvl, sb.size());

    // ---------------- packet mode hold ----------------
    $display("packet hold");
    p_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      p_tv = 1; p_td = 8'hA1 + 8'(i); p_tl = (i == 2);
      #1;
      check("pk_hold_tvalid", p_mv, 0);
      tick();
    end
    p_tv = 0; p_tl = 0;
    check("pk_rel_tvalid", p_mv,  1);
    check("pk_rel_pkt",    p_pc,  1);
    check("pk_rel_level",  p_lvl, 3);
    for (int j = 0; j < 3; j++) begin
      check("pk_rd_beat", {p_ml, p_md}, {(j == 2), 8'hA1 + 8'(j)});
      tick();
    end
    p_rdy = 0;
    check("pk_after_pkt",    p_pc,  0);
    check("pk_after_tvalid", p_mv,  0);
    check("pk_after_level",  p_lvl, 0);

    // ---------------- oversize ----------------
    $display("oversize");
    for (int i = 0; i < 8; i++) begin
      p_tv = 1; p_td = 8'hB0 + 8'(i); p_tl = 0;
      tick();
    end
    p_tv = 0;
    check("ovs_full_level",  p_lvl,  8);
    check("ovs_full_tready", p_trdy, 0);
    check("ovs_pre_tvalid",  p_mv,   0);
    check("ovs_pre_flag",    p_ov,   0);
    tick();
    check("ovs_flag",   p_ov, 1);
    check("ovs_tvalid", p_mv, 1);
    check("ovs_tdata",  p_md, 8'hB0);
    p_rdy = 1;
    tick();
    p_rdy = 0;
    check("ovs_level7", p_lvl,  7);
    check("ovs_tready", p_trdy, 1);
    p_tv = 1; p_td = 8'hB8; p_tl = 1;
    tick();
    p_tv = 0; p_tl = 0;
    check("ovs_pkt1",   p_pc,  1);
    check("ovs_level8", p_lvl, 8);
    p_rdy = 1;
    for (int j = 1; j <= 8; j++) begin
      check("ovs_rd_beat", {p_ml, p_md}, {(j == 8), 8'hB0 + 8'(j)});
      tick();
    end
    p_rdy = 0;
    check("ovs_end_level", p_lvl, 0);
    check("ovs_end_pkt",   p_pc,  0);
    check("ovs_sticky",    p_ov,  1);
    // Back in IDLE, a lone non-last beat must be held.
    p_tv = 1; p_td = 8'hC0; p_tl = 0;
    tick();
    p_tv = 0;
    check("ovs_idle_level",  p_lvl, 1);
    check("ovs_idle_tvalid", p_mv,  0);

    // ---------------- flush mid-stream ----------------
    $display("flush");
    for (int i = 1; i <= 4; i++) begin
      p_tv = 1; p_td = 8'hC0 + 8'(i); p_tl = (i == 2);
      tick();
    end
    p_tv = 0; p_tl = 0;
    check("fl_pre_level",  p_lvl, 5);
    check("fl_pre_tvalid", p_mv,  1);
    p_flush = 1; p_tv = 1; p_td = 8'hDD; p_tl = 1; p_rdy = 1;
    #1;
    check("fl_tready", p_trdy, 0);
    tick();
    p_flush = 0; p_tv = 0; p_tl = 0; p_rdy = 0;
    check("fl_level",  p_lvl, 0);
    check("fl_tvalid", p_mv,  0);
    check("fl_pkt",    p_pc,  0);
    check("fl_ovs",    p_ov,  0);
    check("fl_ae",     p_ae,  1);
    p_tv = 1; p_td = 8'hE1; p_tl = 1;
    tick();
    p_tv = 0; p_tl = 0;
    check("fl_post_level",  p_lvl, 1);
    check("fl_post_tvalid", p_mv,  1);
    check("fl_post_beat",   {p_ml, p_md}, 9'h1E1);

    // ---------------- reset mid-operation ----------------
    $display("reset mid-op");
    for (int i = 1; i <= 4; i++) begin
      c_tv = 1; c_td = 8'hF0 + 8'(i); c_tl = (i == 4);
      tick();
    end
    c_tv = 0; c_tl = 0;
    check("mr_pre_level", c_lvl, 4);
    c_rst = 1; c_tv = 1; c_td = 8'h77; c_rdy = 1;
    #1;
    check("mr_tready_during", c_trdy, 0);
    tick();
    c_rst = 0; c_tv = 0; c_rdy = 0;
    #1;
    check("mr_level",  c_lvl,  0);
    check("mr_tvalid", c_mv,   0);
    check("mr_pkt",    c_pc,   0);
    check("mr_ae",     c_ae,   1);
    check("mr_af",     c_af,   0);
    check("mr_ovs",    c_ov,   0);
    check("mr_tready", c_trdy, 1);
    c_tv = 1; c_td = 8'h55; c_tl = 1;
    tick();
    c_tv = 0; c_tl = 0;
    check("mr_post_level", c_lvl, 1);
    check("mr_post_beat",  {c_mv, c_ml, c_md}, 10'h355);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
